lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning data-memory byte-address width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port req_valid, input, 1 bit: core presents a load/store request.
REQ-005 The block SHALL have port req_ready, output, 1 bit: block accepts the request this cycle.
REQ-006 The block SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-007 The block SHALL have ports req_addr (input, 32 bits, byte address), req_funct3 (input, 3 bits, RISC-V size/sign code) and req_wdata (input, 32 bits, store data).
REQ-008 The block SHALL have ports rsp_valid (output, 1 bit), rsp_ready (input, 1 bit), rsp_rdata (output, 32 bits, load data) and rsp_fault (output, 1 bit, request rejected).
REQ-009 The block SHALL have ports mem_read (output, 1 bit), mem_write (output, 1 bit), mem_addr (output, ADDR_W bits), mem_wdata (output, 32 bits), mem_funct3 (output, 3 bits) and mem_rdata (input, 32 bits, combinational read data from the data memory).

Function
REQ-010 The FSM SHALL have states IDLE, ACCESS and RESP.
REQ-011 The block SHALL drive req_ready=1 only in IDLE; an accept is req_valid && req_ready.
REQ-012 On accept, the block SHALL register we, addr, funct3 and wdata, and SHALL evaluate the fault condition on the request.
REQ-013 A fault SHALL be raised for any of: funct3 in {011,110,111}; store with funct3 in {100,101}; halfword access (funct3 x01) with addr[0]=1; word access with addr[1:0]!=0; addr[31:ADDR_W]!=0.
REQ-014 A faulting accept SHALL go IDLE->RESP with rsp_fault=1 and rsp_rdata=0, and SHALL assert neither mem_read nor mem_write.
REQ-015 A non-faulting accept SHALL go IDLE->ACCESS.
REQ-016 In ACCESS, for exactly one cycle, the block SHALL drive mem_addr=addr[ADDR_W-1:0], mem_funct3=funct3 and mem_wdata=wdata, with mem_write=we and mem_read=!we.
REQ-017 At the end of ACCESS, a load SHALL capture mem_rdata into rsp_rdata and a store SHALL set rsp_rdata=0; the state SHALL then go ACCESS->RESP.
REQ-018 In RESP, rsp_valid SHALL be 1 and rsp_rdata/rsp_fault SHALL be held stable until rsp_valid && rsp_ready.
REQ-019 On rsp_valid && rsp_ready the state SHALL go RESP->IDLE; a new request SHALL NOT be accepted in that same cycle.
REQ-020 Latency from accept to rsp_valid SHALL be 2 cycles for a normal request and 1 cycle for a fault; throughput is one request per 3 cycles minimum.
REQ-021 Outside ACCESS, mem_read and mem_write SHALL be 0, and mem_addr, mem_wdata and mem_funct3 SHALL be 0.
REQ-022 At most one request SHALL be outstanding; req_* inputs SHALL be ignored outside IDLE.

Reset
REQ-023 While rst_n=0 at a clock edge, the state SHALL become IDLE and rsp_valid, rsp_fault, rsp_rdata, mem_read and mem_write SHALL all become 0.
REQ-024 Reset asserted during ACCESS SHALL abort the access; because the memory commits on the same edge, a store in flight may or may not have committed, and the bench SHALL NOT check memory contents for that case.
REQ-025 Reset asserted during RESP SHALL drop the pending response without handshake.

Structure
REQ-026 A shared package SHALL hold the funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW) and the state enum typedef.
REQ-027 lsu_ctrl SHALL instantiate no sub-module; the alignment/legality check SHALL be a function in the shared package; the bench SHALL pair lsu_ctrl with the existing data memory.

Verification
REQ-028 Scenario: memory byte 0..3 = EE,DD,CC,FF; lw addr 0 -> rsp_rdata=0xFFCCDDEE, rsp_fault=0, rsp_valid 2 cycles after accept.
REQ-029 Scenario: lb addr 0 -> 0xFFFFFFEE; lbu addr 0 -> 0x000000EE; lhu addr 2 -> 0x0000FFCC.
REQ-030 Scenario: sw 0x12345678 at addr 8, then lw addr 8 -> 0x12345678; mem_write is high for exactly one cycle during the store.
REQ-031 Scenario: lh addr 1, sw addr 6 and lw addr 0x100 -> each gives rsp_fault=1 one cycle after accept, with mem_read/mem_write never asserted.
REQ-032 Scenario: rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stay stable and req_ready=0; on release, return to IDLE next cycle.
REQ-033 Scenario: rst_n=0 during RESP -> next cycle rsp_valid=0, req_ready=1, and a following lw addr 0 returns 0xFFCCDDEE.

Source files
------------

// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store unit controller: funct3 size codes,
// controller state encoding and the request legality check.
package lsu_ctrl_pkg;

    // RISC-V funct3 codes for loads and stores (stores reuse the load codes).
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_e;

    // Returns 1 when a request must be rejected without touching memory:
    // unknown size code, unsigned store, misaligned access, or an address
    // beyond the data memory.
    function automatic logic lsu_fault(input logic        we,
                                       input logic [31:0] addr,
                                       input logic [2:0]  funct3,
                                       input int          addr_w);
        logic bad_code;
        logic bad_store;
        logic bad_align;
        logic bad_range;
        bad_code  = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
        bad_store = we && funct3[2];
        bad_align = ((funct3[1:0] == 2'b01) && addr[0]) ||
                    ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        bad_range = (addr >> addr_w) != 32'd0;
        return bad_code || bad_store || bad_align || bad_range;
    endfunction

endpackage

// File: rtl/lsu_ctrl_dmem.sv
// Byte-addressed data memory: combinational sized/sign-extended read,
// sized write committed on the rising clock edge.
module lsu_ctrl_dmem
    import lsu_ctrl_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        funct3,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] a1;
    logic [ADDR_W-1:0] a2;
    logic [ADDR_W-1:0] a3;

    assign a1 = addr + ADDR_W'(1);
    assign a2 = addr + ADDR_W'(2);
    assign a3 = addr + ADDR_W'(3);

    // Commit byte, halfword or word stores, little-endian.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata[7:0];
            if (funct3 == SH || funct3 == SW) begin
                mem[a1] <= wdata[15:8];
            end
            if (funct3 == SW) begin
                mem[a2] <= wdata[23:16];
                mem[a3] <= wdata[31:24];
            end
        end
    end

    // Assemble and extend the read value according to the access size.
    always_comb begin
        rdata = '0;
        case (funct3)
            LB:      rdata = {{24{mem[addr][7]}}, mem[addr]};
            LH:      rdata = {{16{mem[a1][7]}}, mem[a1], mem[addr]};
            LW:      rdata = {mem[a3], mem[a2], mem[a1], mem[addr]};
            LBU:     rdata = {24'd0, mem[addr]};
            LHU:     rdata = {16'd0, mem[a1], mem[addr]};
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one core request at a time, rejects
// illegal ones immediately, otherwise drives a single-cycle memory access
// and holds the response until the core takes it.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_fault,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [2:0]        mem_funct3,
    input  logic [31:0]       mem_rdata
);

    lsu_state_e        state_q;
    lsu_state_e        state_d;
    logic              accept;
    logic              req_fault;

    logic              we_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [2:0]        funct3_p0;
    logic [31:0]       wdata_p0;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, handshakes and memory strobes; memory bus is zero outside ACCESS.
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        accept     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_funct3 = '0;
        req_fault  = lsu_fault(req_we, req_addr, req_funct3, ADDR_W);
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = req_fault ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                mem_read   = !we_p0;
                mem_write  = we_p0;
                mem_addr   = addr_p0;
                mem_wdata  = wdata_p0;
                mem_funct3 = funct3_p0;
                state_d    = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request capture on accept; only consumed in ACCESS, so no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_p0     <= req_we;
            addr_p0   <= req_addr[ADDR_W-1:0];
            funct3_p0 <= req_funct3;
            wdata_p0  <= req_wdata;
        end
    end

    // Response payload: fault flag set at accept, load data latched at end of ACCESS.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_fault <= 1'b0;
            rsp_rdata <= '0;
        end else if (accept) begin
            rsp_fault <= req_fault;
            rsp_rdata <= '0;
        end else if (state_q == ACCESS) begin
            rsp_rdata <= we_p0 ? 32'd0 : mem_rdata;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl paired with its data memory.
module tb_lsu_ctrl;
    import lsu_ctrl_pkg::*;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [31:0]   req_addr;
    logic [2:0]    req_funct3;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_fault;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [2:0]    mem_funct3;
    logic [31:0]   mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [7:0] mm [256];

    always #5 clk = ~clk;

    lsu_ctrl #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_fault(rsp_fault),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
    );

    lsu_ctrl_dmem #(.ADDR_W(AW)) dmem (
        .clk(clk), .we(mem_write), .addr(mem_addr), .funct3(mem_funct3),
        .wdata(mem_wdata), .rdata(mem_rdata)
    );

    // Reference: access size in bytes, 0 for an unknown code.
    function automatic int unsigned m_size(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic logic m_fault(input logic we, input logic [31:0] a, input logic [2:0] f3);
        int unsigned sz;
        int unsigned ua;
        sz = m_size(f3);
        ua = a;
        if (sz == 0) return 1'b1;
        if (we && f3 >= 3'd4) return 1'b1;
        if (ua % sz != 0) return 1'b1;
        if (ua >= 256) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] f3);
        int unsigned i;
        int v;
        i = a;
        v = 0;
        case (f3)
            3'd0: begin v = int'(mm[i]); if (v >= 128) v -= 256; end
            3'd4: v = int'(mm[i]);
            3'd1: begin v = int'(mm[i]) + 256 * int'(mm[i+1]); if (v >= 32768) v -= 65536; end
            3'd5: v = int'(mm[i]) + 256 * int'(mm[i+1]);
            3'd2: return {mm[i+3], mm[i+2], mm[i+1], mm[i]};
            default: v = 0;
        endcase
        return 32'(v);
    endfunction

    task automatic m_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd);
        int unsigned i;
        i = a;
        for (int k = 0; k < int'(m_size(f3)); k++) begin
            mm[i+k] = wd[8*k +: 8];
        end
    endtask

    // Runs one request through the full handshake and reports what was observed.
    task automatic xact(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                        input logic [31:0] wd, input int stall,
                        output logic [31:0] rd, output logic flt, output int lat,
                        output int rdc, output int wrc, output logic side_ok);
        side_ok = 1'b1; rdc = 0; wrc = 0; lat = -1; rd = '0; flt = 1'b0;
        @(negedge clk);
        if (req_ready !== 1'b1) side_ok = 1'b0;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_funct3 = f3; req_wdata = wd;
        for (int c = 1; c <= 8 && lat < 0; c++) begin
            @(negedge clk);
            if (req_ready !== 1'b0) side_ok = 1'b0;
            if (mem_read === 1'b1) rdc++;
            if (mem_write === 1'b1) wrc++;
            if (mem_read === 1'b1 || mem_write === 1'b1) begin
                if (mem_addr !== addr[AW-1:0] || mem_wdata !== wd || mem_funct3 !== f3) side_ok = 1'b0;
            end else if (mem_addr !== '0 || mem_wdata !== '0 || mem_funct3 !== '0) begin
                side_ok = 1'b0;
            end
            if (rsp_valid === 1'b1) begin lat = c; rd = rsp_rdata; flt = rsp_fault; end
            req_we = 1'($urandom); req_addr = $urandom; req_funct3 = 3'($urandom);
            req_wdata = $urandom;
        end
        if (lat >= 0) begin
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_fault !== flt ||
                    req_ready !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) side_ok = 1'b0;
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            if (req_ready !== 1'b1 || rsp_valid !== 1'b0) side_ok = 1'b0;
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset req_ready: got %b expected 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (rsp_fault !== 1'b0) begin errors++; $display("FAIL reset rsp_fault: got %b expected 0", rsp_fault); end
        checks++; if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL reset rsp_rdata: got %h expected 0", rsp_rdata); end
        checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("FAIL reset mem strobes: got %b%b expected 00", mem_read, mem_write); end
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        logic [31:0] rd; logic flt, ok; int lat, rdc, wrc; logic [31:0] wd;
        for (int i = 0; i < 64; i++) begin
            wd = $urandom;
            xact(1'b1, 32'(i * 4), SW, wd, 0, rd, flt, lat, rdc, wrc, ok);
            m_store(32'(i * 4), SW, wd);
            checks++; if (flt !== 1'b0 || lat !== 2 || wrc !== 1 || rdc !== 0 || ok !== 1'b1) begin
                errors++; $display("FAIL fill[%0d]: fault %b lat %0d wr %0d rd %0d side %b expected 0 2 1 0 1", i, flt, lat, wrc, rdc, ok);
            end
        end
    endtask

    task automatic test_directed();
        logic        t_we [7] = '{1, 0, 0, 0, 0, 1, 0};
        logic [31:0] t_a  [7] = '{0, 0, 0, 0, 2, 8, 8};
        logic [2:0]  t_f  [7] = '{SW, LW, LB, LBU, LHU, SW, LW};
        logic [31:0] t_wd [7] = '{32'hFFCCDDEE, 0, 0, 0, 0, 32'h12345678, 0};
        logic [31:0] t_ex [7] = '{0, 32'hFFCCDDEE, 32'hFFFFFFEE, 32'h000000EE, 32'h0000FFCC, 0, 32'h12345678};
        logic [31:0] rd; logic flt, ok; int lat, rdc, wrc;
        for (int i = 0; i < 7; i++) begin
            xact(t_we[i], t_a[i], t_f[i], t_wd[i], 0, rd, flt, lat, rdc, wrc, ok);
            if (t_we[i]) m_store(t_a[i], t_f[i], t_wd[i]);
            checks++; if (rd !== t_ex[i] || flt !== 1'b0) begin errors++; $display("FAIL directed[%0d] data: got %h/%b expected %h/0", i, rd, flt, t_ex[i]); end
            checks++; if (lat !== 2) begin errors++; $display("FAIL directed[%0d] latency: got %0d expected 2", i, lat); end
            checks++; if (wrc !== int'(t_we[i]) || rdc !== int'(!t_we[i])) begin errors++; $display("FAIL directed[%0d] strobes: got rd %0d wr %0d expected rd %0d wr %0d", i, rdc, wrc, int'(!t_we[i]), int'(t_we[i])); end
            checks++; if (ok !== 1'b1) begin errors++; $display("FAIL directed[%0d] handshake/bus: got %b expected 1", i, ok); end
        end
    endtask

    task automatic test_faults();
        logic        t_we [6] = '{0, 1, 0, 0, 1, 1};
        logic [31:0] t_a  [6] = '{1, 6, 32'h100, 0, 4, 32'h0000_0101};
        logic [2:0]  t_f  [6] = '{LH, SW, LW, 3'b011, 3'b100, SH};
        logic [31:0] rd; logic flt, ok; int lat, rdc, wrc;
        for (int i = 0; i < 6; i++) begin
            xact(t_we[i], t_a[i], t_f[i], $urandom, 0, rd, flt, lat, rdc, wrc, ok);
            checks++; if (flt !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL fault[%0d] response: got %b/%h expected 1/00000000", i, flt, rd); end
            checks++; if (lat !== 1) begin errors++; $display("FAIL fault[%0d] latency: got %0d expected 1", i, lat); end
            checks++; if (rdc !== 0 || wrc !== 0 || ok !== 1'b1) begin errors++; $display("FAIL fault[%0d] memory untouched: got rd %0d wr %0d side %b expected 0 0 1", i, rdc, wrc, ok); end
        end
    endtask

    task automatic test_stall();
        logic [31:0] rd; logic flt, ok; int lat, rdc, wrc;
        xact(1'b0, 32'd8, LW, 32'd0, 5, rd, flt, lat, rdc, wrc, ok);
        checks++; if (rd !== 32'h12345678 || flt !== 1'b0) begin errors++; $display("FAIL stall data: got %h/%b expected 12345678/0", rd, flt); end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL stall hold/release: got %b expected 1", ok); end
    endtask

    task automatic test_reset_resp();
        logic [31:0] rd; logic flt, ok; int lat, rdc, wrc;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 0; req_funct3 = LW;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL reset_resp pending: got %b expected 1", rsp_valid); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 32'd0) begin
            errors++; $display("FAIL reset_resp drop: got valid %b ready %b rdata %h expected 0 1 00000000", rsp_valid, req_ready, rsp_rdata);
        end
        xact(1'b0, 32'd0, LW, 32'd0, 0, rd, flt, lat, rdc, wrc, ok);
        checks++; if (rd !== 32'hFFCCDDEE || flt !== 1'b0 || lat !== 2) begin errors++; $display("FAIL reset_resp reload: got %h/%b lat %0d expected ffccddee/0 lat 2", rd, flt, lat); end
    endtask

    task automatic test_reset_access();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'd4; req_funct3 = LW;
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL reset_access in access: got mem_read %b expected 1", mem_read); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem_read !== 1'b0) begin
            errors++; $display("FAIL reset_access abort: got valid %b ready %b mem_read %b expected 0 1 0", rsp_valid, req_ready, mem_read);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, a, wd, exp_rd; logic flt, ok, we, ef; int lat, rdc, wrc, r, stall; logic [2:0] f3;
        for (int i = 0; i < 150; i++) begin
            we = 1'($urandom); f3 = 3'($urandom); r = $urandom_range(0, 9);
            wd = $urandom; stall = $urandom_range(0, 3);
            a = (r == 0) ? $urandom : ($urandom_range(0, 255) & ((r < 6) ? 32'hFC : 32'hFF));
            ef = m_fault(we, a, f3);
            exp_rd = (ef || we) ? 32'd0 : m_load(a, f3);
            xact(we, a, f3, wd, stall, rd, flt, lat, rdc, wrc, ok);
            if (!ef && we) m_store(a, f3, wd);
            checks++; if (flt !== ef) begin errors++; $display("FAIL rand[%0d] fault we=%b a=%h f3=%0d: got %b expected %b", i, we, a, f3, flt, ef); end
            checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rand[%0d] rdata a=%h f3=%0d: got %h expected %h", i, a, f3, rd, exp_rd); end
            checks++; if (lat !== (ef ? 1 : 2)) begin errors++; $display("FAIL rand[%0d] latency: got %0d expected %0d", i, lat, ef ? 1 : 2); end
            checks++; if (rdc !== int'(!ef && !we) || wrc !== int'(!ef && we)) begin errors++; $display("FAIL rand[%0d] strobes: got rd %0d wr %0d expected rd %0d wr %0d", i, rdc, wrc, int'(!ef && !we), int'(!ef && we)); end
            checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rand[%0d] handshake/bus: got %b expected 1", i, ok); end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_funct3 = '0; req_wdata = '0; rsp_ready = 1'b0;
        for (int i = 0; i < 256; i++) mm[i] = 8'h00;
        test_reset();
        test_fill();
        test_directed();
        test_faults();
        test_stall();
        test_reset_resp();
        test_reset_access();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
